// File: rtl/bus_if_wb.sv
// bus_if_wb: MEM-stage bus interface with a posted-write buffer.
// Accesses whose slave index equals SPM_IDX go straight to the scratch-pad.
// All other accesses go to the shared bus. Bus writes are posted into a
// WBUF_DEPTH-entry FIFO. Bus reads wait until that FIFO has drained.
// Optional feature macro: BUS_IF_TIMEOUT_EN. It adds an ACCESS-state timeout
// that aborts the transfer and pulses bus_err.
module bus_if_wb #(
    parameter int ADDR_W      = 30,
    parameter int DATA_W      = 32,
    parameter int IDX_W       = 3,
    parameter int SPM_IDX     = 1,
    parameter int WBUF_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                flush,
    output logic                busy,
    output logic                bus_err,
    input  logic [ADDR_W-1:0]   addr,
    input  logic                as_,
    input  logic                rw,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data,
    input  logic [DATA_W-1:0]   spm_rd_data,
    output logic [ADDR_W-1:0]   spm_addr,
    output logic                spm_as_,
    output logic                spm_rw,
    output logic [DATA_W/8-1:0] spm_be,
    output logic [DATA_W-1:0]   spm_wr_data,
    input  logic [DATA_W-1:0]   bus_rd_data,
    input  logic                bus_rdy_,
    input  logic                bus_grnt_,
    output logic                bus_req_,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic                bus_as_,
    output logic                bus_rw,
    output logic [DATA_W/8-1:0] bus_be,
    output logic [DATA_W-1:0]   bus_wr_data
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = $clog2(WBUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = ADDR_W + BE_W + DATA_W;

    typedef enum logic [1:0] {IDLE, REQ, ACCESS, STALL} state_t;

    state_t              state_reg;
    logic [DATA_W-1:0]   rd_buf_reg;

    // Write buffer storage and bookkeeping
    logic [ENT_W-1:0]    wbuf_mem [WBUF_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    logic [IDX_W-1:0]    idx;
    logic                is_spm;
    logic                req_valid;
    logic                bus_wr_req;
    logic                bus_rd_req;
    logic                spm_rd_sel;
    logic                full;
    logic                empty;
    logic                push;
    logic                pop;
    logic                timeout_hit;
    logic                xfer_end;
    logic                rd_done;
    logic                rd_inflight;
    logic [ENT_W-1:0]    head;
    logic [ADDR_W-1:0]   head_addr;
    logic [BE_W-1:0]     head_be;
    logic [DATA_W-1:0]   head_data;

    // Request decode
    assign idx        = addr[ADDR_W-1 -: IDX_W];
    assign is_spm     = (idx == IDX_W'(SPM_IDX));
    assign req_valid  = ~as_ & ~flush;
    assign bus_wr_req = req_valid & ~is_spm & ~rw;
    assign bus_rd_req = req_valid & ~is_spm & rw;
    assign spm_rd_sel = req_valid & is_spm & rw;

    // Buffer status. full is taken from the current count, so a push is
    // refused when the buffer is full even if a pop happens in the same cycle.
    assign full  = (count_reg == CNT_W'(WBUF_DEPTH));
    assign empty = (count_reg == '0);
    assign push  = bus_wr_req & ~stall & ~full;

    // A transfer ends on ready or on an abort
    assign xfer_end    = ~bus_rdy_ | timeout_hit;
    assign pop         = (state_reg == ACCESS) & ~bus_rw & xfer_end;
    assign rd_done     = (state_reg == ACCESS) & bus_rw & xfer_end;
    assign rd_inflight = ((state_reg == ACCESS) & bus_rw) | (state_reg == STALL);

    assign head      = wbuf_mem[rd_ptr_reg];
    assign head_addr = head[ENT_W-1 -: ADDR_W];
    assign head_be   = head[DATA_W +: BE_W];
    assign head_data = head[DATA_W-1:0];

    // The scratch-pad path is combinational and runs in parallel with the bus FSM
    assign spm_addr    = addr;
    assign spm_rw      = rw;
    assign spm_be      = be;
    assign spm_wr_data = wr_data;
    assign spm_as_     = ~(req_valid & is_spm & ~stall & ~rd_inflight);

`ifdef BUS_IF_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC < 256) ? 8 : 16;
    logic [TO_W-1:0] to_cnt_reg;

    // Count ACCESS cycles without ready. The count restarts on every entry into ACCESS.
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt_reg <= '0;
        end else if (state_reg == REQ && !bus_grnt_) begin
            to_cnt_reg <= '0;
        end else if (state_reg == ACCESS && bus_rdy_) begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
        end
    end

    assign timeout_hit = (state_reg == ACCESS) & bus_rdy_ &
                         (to_cnt_reg == TO_W'(TIMEOUT_CYC - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Buffer storage: written on push and never reset
    always_ff @(posedge clk) begin
        if (push) begin
            wbuf_mem[wr_ptr_reg] <= {addr, be, wr_data};
        end
    end

    // Buffer pointers and occupancy. Pointers wrap at WBUF_DEPTH because it is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Bus FSM. Buffered writes have priority over reads. All bus outputs are registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            bus_req_    <= 1'b1;
            bus_as_     <= 1'b1;
            bus_rw      <= 1'b1;
            bus_addr    <= '0;
            bus_be      <= '0;
            bus_wr_data <= '0;
            rd_buf_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (!empty) begin
                        state_reg   <= REQ;
                        bus_req_    <= 1'b0;
                        bus_addr    <= head_addr;
                        bus_rw      <= 1'b0;
                        bus_be      <= head_be;
                        bus_wr_data <= head_data;
                    end else if (bus_rd_req) begin
                        state_reg   <= REQ;
                        bus_req_    <= 1'b0;
                        bus_addr    <= addr;
                        bus_rw      <= 1'b1;
                        bus_be      <= be;
                        bus_wr_data <= wr_data;
                    end
                end
                REQ: begin
                    if (!bus_grnt_) begin
                        state_reg <= ACCESS;
                        bus_as_   <= 1'b0;
                    end
                end
                ACCESS: begin
                    bus_as_ <= 1'b1;
                    if (xfer_end) begin
                        bus_req_    <= 1'b1;
                        bus_addr    <= '0;
                        bus_be      <= '0;
                        bus_wr_data <= '0;
                        bus_rw      <= 1'b1;
                        if (bus_rw) begin
                            rd_buf_reg <= timeout_hit ? '0 : bus_rd_data;
                            state_reg  <= (stall && !timeout_hit) ? STALL : IDLE;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                STALL: begin
                    if (!stall) state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Registered one-cycle pulse that follows an aborted access
    always_ff @(posedge clk) begin
        if (reset) bus_err <= 1'b0;
        else       bus_err <= timeout_hit;
    end

    // Read data select: held bus data, live bus data, or scratch-pad data
    always_comb begin
        rd_data = '0;
        if (state_reg == STALL) begin
            rd_data = rd_buf_reg;
        end else if (rd_done) begin
            rd_data = timeout_hit ? '0 : bus_rd_data;
        end else if (spm_rd_sel) begin
            rd_data = spm_rd_data;
        end
    end

    // Stall request. A write stalls only when the buffer is full. A read stalls until its data returns.
    always_comb begin
        busy = 1'b0;
        if (bus_wr_req && full) busy = 1'b1;
        if (bus_rd_req && !rd_done && state_reg != STALL) busy = 1'b1;
    end

endmodule

// File: tb/tb_bus_if_wb.sv
// tb_bus_if_wb: directed self-checking bench for bus_if_wb.
// The bench plays the part of the bus slave and arbiter.
module tb_bus_if_wb;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        busy;
    logic        bus_err;
    logic [29:0] addr;
    logic        as_;
    logic        rw;
    logic [3:0]  be;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic [31:0] spm_rd_data;
    logic [29:0] spm_addr;
    logic        spm_as_;
    logic        spm_rw;
    logic [3:0]  spm_be;
    logic [31:0] spm_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic        bus_grnt_;
    logic        bus_req_;
    logic [29:0] bus_addr;
    logic        bus_as_;
    logic        bus_rw;
    logic [3:0]  bus_be;
    logic [31:0] bus_wr_data;

    int n_cmp = 0;
    int n_err = 0;

    localparam logic [29:0] SPM_A = 30'h0800_0010;  // index 1
    localparam logic [29:0] BA    = 30'h1000_0000;  // index 2

    bus_if_wb #(
        .ADDR_W(30), .DATA_W(32), .IDX_W(3), .SPM_IDX(1),
        .WBUF_DEPTH(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .busy(busy), .bus_err(bus_err),
        .addr(addr), .as_(as_), .rw(rw), .be(be), .wr_data(wr_data),
        .rd_data(rd_data),
        .spm_rd_data(spm_rd_data), .spm_addr(spm_addr), .spm_as_(spm_as_),
        .spm_rw(spm_rw), .spm_be(spm_be), .spm_wr_data(spm_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .bus_grnt_(bus_grnt_),
        .bus_req_(bus_req_), .bus_addr(bus_addr), .bus_as_(bus_as_),
        .bus_rw(bus_rw), .bus_be(bus_be), .bus_wr_data(bus_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu(input logic a_n, input logic r, input logic [29:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        as_ = a_n; rw = r; addr = a; be = b; wr_data = d;
    endtask

    // Wait for a bus transfer to start, check it, and answer with ready
    task automatic serve(input string tag, input logic [29:0] ea, input logic [3:0] ebe,
                         input logic [31:0] ed, input logic erw, input logic [31:0] rdv,
                         input logic hold_stall);
        bit found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus_as_ === 1'b0) begin
                found = 1'b1;
                break;
            end
            step();
        end
        check({tag, "_as_seen"}, 64'(found), 64'd1);
        check({tag, "_addr"}, 64'(bus_addr), 64'(ea));
        check({tag, "_be"}, 64'(bus_be), 64'(ebe));
        check({tag, "_rw"}, 64'(bus_rw), 64'(erw));
        if (!erw) check({tag, "_wdata"}, 64'(bus_wr_data), 64'(ed));
        $display("bus xfer %s rw=%0d addr=%h be=%h wdata=%h", tag, bus_rw, bus_addr, bus_be, bus_wr_data);
        bus_rdy_ = 1'b0;
        bus_rd_data = rdv;
        if (hold_stall) stall = 1'b1;
        #1;
        if (erw) begin
            check({tag, "_rdata"}, 64'(rd_data), 64'(rdv));
            check({tag, "_rd_busy"}, 64'(busy), 64'd0);
        end
        step();
        bus_rdy_ = 1'b1;
        bus_rd_data = 32'hDEAD_BEEF;
        check({tag, "_req_rel"}, 64'(bus_req_), 64'd1);
        check({tag, "_addr_clr"}, 64'(bus_addr), 64'd0);
        check({tag, "_be_clr"}, 64'(bus_be), 64'd0);
        check({tag, "_rw_rd"}, 64'(bus_rw), 64'd1);
    endtask

    logic [3:0]  be_tab [5];

    initial begin
        be_tab[0] = 4'b0001; be_tab[1] = 4'b0011; be_tab[2] = 4'b0100;
        be_tab[3] = 4'b1000; be_tab[4] = 4'b1111;

        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        cpu(1'b1, 1'b1, '0, '0, '0);
        spm_rd_data = '0; bus_rd_data = '0; bus_rdy_ = 1'b1; bus_grnt_ = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        #1;

        // Reset state
        check("rst_req", 64'(bus_req_), 64'd1);
        check("rst_as", 64'(bus_as_), 64'd1);
        check("rst_rw", 64'(bus_rw), 64'd1);
        check("rst_addr", 64'(bus_addr), 64'd0);
        check("rst_be", 64'(bus_be), 64'd0);
        check("rst_wdata", 64'(bus_wr_data), 64'd0);
        check("rst_err", 64'(bus_err), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_spm_as", 64'(spm_as_), 64'd1);

        // SPM read: same-cycle data and no bus activity
        cpu(1'b0, 1'b1, SPM_A, 4'hF, '0);
        spm_rd_data = 32'hA5A5_A5A5;
        #1;
        check("spm_rdata", 64'(rd_data), 64'hA5A5_A5A5);
        check("spm_busy", 64'(busy), 64'd0);
        check("spm_as", 64'(spm_as_), 64'd0);
        check("spm_addr", 64'(spm_addr), 64'(SPM_A));
        $display("spm read addr=%h rdata=%h", spm_addr, rd_data);
        step();
        check("spm_no_req", 64'(bus_req_), 64'd1);
        cpu(1'b1, 1'b1, '0, '0, '0);
        step();

        // Five back-to-back posted writes with the grant withheld
        for (int i = 0; i < 4; i++) begin
            cpu(1'b0, 1'b0, BA + 30'(i), be_tab[i], 32'hC0DE_0000 + 32'(i));
            #1;
            check($sformatf("wr%0d_busy", i), 64'(busy), 64'd0);
            $display("post write %0d addr=%h", i, addr);
            step();
        end
        cpu(1'b0, 1'b0, BA + 30'd4, be_tab[4], 32'hC0DE_0004);
        #1;
        check("wr4_full_busy", 64'(busy), 64'd1);
        check("wr_req_low", 64'(bus_req_), 64'd0);
        step();
        check("wr4_busy_c5", 64'(busy), 64'd1);
        step();
        check("wr4_busy_c6", 64'(busy), 64'd1);
        bus_grnt_ = 1'b0;
        step();
        check("w0_as", 64'(bus_as_), 64'd0);
        check("w0_addr", 64'(bus_addr), 64'(BA));
        check("w0_be", 64'(bus_be), 64'(be_tab[0]));
        check("w0_wdata", 64'(bus_wr_data), 64'hC0DE_0000);
        check("w0_rw", 64'(bus_rw), 64'd0);
        $display("bus xfer w0 addr=%h be=%h", bus_addr, bus_be);
        bus_rdy_ = 1'b0;
        #1;
        check("wr4_busy_pop_cycle", 64'(busy), 64'd1);
        step();
        bus_rdy_ = 1'b1;
        #1;
        check("wr4_busy_after_pop", 64'(busy), 64'd0);
        check("w0_req_rel", 64'(bus_req_), 64'd1);
        check("w0_addr_clr", 64'(bus_addr), 64'd0);
        step();
        cpu(1'b1, 1'b1, '0, '0, '0);
        for (int i = 1; i < 5; i++) begin
            serve($sformatf("w%0d", i), BA + 30'(i), be_tab[i],
                  32'hC0DE_0000 + 32'(i), 1'b0, 32'h0, 1'b0);
        end

        // Two buffered writes followed by a bus read
        cpu(1'b0, 1'b0, BA + 30'h10, 4'b0011, 32'hAAAA_0001);
        step();
        cpu(1'b0, 1'b0, BA + 30'h11, 4'b1100, 32'hAAAA_0002);
        step();
        cpu(1'b0, 1'b1, BA + 30'h20, 4'hF, 32'h0);
        #1;
        check("rd_wait_busy", 64'(busy), 64'd1);
        serve("wa", BA + 30'h10, 4'b0011, 32'hAAAA_0001, 1'b0, 32'h0, 1'b0);
        serve("wb", BA + 30'h11, 4'b1100, 32'hAAAA_0002, 1'b0, 32'h0, 1'b0);
        serve("rd", BA + 30'h20, 4'hF, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
        cpu(1'b1, 1'b1, '0, '0, '0);
        step();

        // Read completing under stall
        cpu(1'b0, 1'b1, BA + 30'h30, 4'hF, 32'h0);
        serve("rds", BA + 30'h30, 4'hF, 32'h0, 1'b1, 32'h1234_5678, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("stall%0d_rdata", i), 64'(rd_data), 64'h1234_5678);
            check($sformatf("stall%0d_busy", i), 64'(busy), 64'd0);
            step();
        end
        stall = 1'b0;
        #1;
        check("stall_exit_rdata", 64'(rd_data), 64'h1234_5678);
        step();
        cpu(1'b0, 1'b1, SPM_A, 4'hF, '0);
        spm_rd_data = 32'h5A5A_1234;
        #1;
        check("post_stall_spm_as", 64'(spm_as_), 64'd0);
        check("post_stall_spm_rdata", 64'(rd_data), 64'h5A5A_1234);
        check("post_stall_req", 64'(bus_req_), 64'd1);
        cpu(1'b1, 1'b1, '0, '0, '0);
        step();

        // flush blocks new requests but not buffered writes
        flush = 1'b1;
        cpu(1'b0, 1'b0, BA + 30'h50, 4'hF, 32'hBAD0_0001);
        #1;
        check("flush_wr_busy", 64'(busy), 64'd0);
        step();
        cpu(1'b0, 1'b1, BA + 30'h51, 4'hF, 32'h0);
        #1;
        check("flush_rd_busy", 64'(busy), 64'd0);
        check("flush_no_req1", 64'(bus_req_), 64'd1);
        step();
        check("flush_no_req2", 64'(bus_req_), 64'd1);
        flush = 1'b0;
        cpu(1'b0, 1'b0, BA + 30'h40, 4'b1000, 32'h0F0F_0F0F);
        step();
        flush = 1'b1;
        cpu(1'b0, 1'b0, BA + 30'h52, 4'hF, 32'hBAD0_0002);
        serve("wf", BA + 30'h40, 4'b1000, 32'h0F0F_0F0F, 1'b0, 32'h0, 1'b0);
        flush = 1'b0;
        cpu(1'b1, 1'b1, '0, '0, '0);
        step();
        step();
        check("flush_idle_req", 64'(bus_req_), 64'd1);

`ifdef BUS_IF_TIMEOUT_EN
        // Timeout: ready never arrives
        begin
            bit found = 1'b0;
            cpu(1'b0, 1'b1, BA + 30'h60, 4'hF, 32'h0);
            bus_rd_data = 32'hFFFF_0000;
            for (int i = 0; i < 20; i++) begin
                if (bus_as_ === 1'b0) begin
                    found = 1'b1;
                    break;
                end
                step();
            end
            check("to_as_seen", 64'(found), 64'd1);
            for (int k = 1; k < 8; k++) begin
                check($sformatf("to_busy_%0d", k), 64'(busy), 64'd1);
                check($sformatf("to_err_%0d", k), 64'(bus_err), 64'd0);
                step();
            end
            check("to_rdata", 64'(rd_data), 64'd0);
            check("to_busy_abort", 64'(busy), 64'd0);
            step();
            cpu(1'b1, 1'b1, '0, '0, '0);
            check("to_err_pulse", 64'(bus_err), 64'd1);
            check("to_req_rel", 64'(bus_req_), 64'd1);
            $display("timeout abort seen, bus_err=%0d", bus_err);
            step();
            check("to_err_clear", 64'(bus_err), 64'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
